// File: rtl/gf2_digit_serial_mult.sv
// rtl/gf2_digit_serial_mult.sv - digit-serial GF(2) polynomial multiplier with optional mod x^N-1 fold
module gf2_digit_serial_mult #(
    parameter int N         = 256,
    parameter int D         = 16,
    parameter int CYCLIC_EN = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           cyc,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] c
);

    localparam int K  = (N + D - 1) / D;
    localparam int BW = K * D;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     a_q;
    logic [BW-1:0]    b_q;
    logic             cyc_q;
    logic [2*N-1:0]   acc;
    logic [KW-1:0]    k;
    logic [2*N-1:0]   pp;
    logic             last_digit;

    assign last_digit = (k == KW'(K - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_digit) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // b_q is shifted down each RUN cycle, so the current digit always sits in b_q[D-1:0]
    always_comb begin
        pp = '0;
        for (int j = 0; j < D; j++) begin
            pp = pp ^ ((({{N{1'b0}}, a_q}) & {(2*N){b_q[j]}}) << j);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            cyc_q <= 1'b0;
            acc   <= '0;
            k     <= '0;
            c     <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= BW'(b);
                        cyc_q <= (CYCLIC_EN != 0) && cyc;
                        acc   <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    acc <= acc ^ (pp << (32'(k) * 32'(D)));
                    b_q <= b_q >> D;
                    k   <= k + KW'(1);
                end
                FINISH: begin
                    // folding the upper half onto the lower one is reduction mod x^N - 1
                    if (cyc_q) begin
                        c <= {{N{1'b0}}, acc[N-1:0] ^ acc[2*N-1:N]};
                    end else begin
                        c <= acc;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf2_digit_serial_mult.sv
// tb/tb_gf2_digit_serial_mult.sv - self-checking bench for gf2_digit_serial_mult over several N/D shapes
module tb_gf2_digit_serial_mult;

    logic         clk;
    logic         reset;
    logic [3:0]   st;
    logic [3:0]   cy;
    logic [3:0]   bz;
    logic [3:0]   dn;
    logic [255:0] av [4];
    logic [255:0] bv [4];
    logic [15:0]  c0;
    logic [19:0]  c1;
    logic [511:0] c2;
    logic [15:0]  c3;

    int checks;
    int failures;

    // instance 0: N=8 D=3, 1: N=10 D=4, 2: N=256 D=16, 3: N=8 D=8
    gf2_digit_serial_mult #(.N(8), .D(3), .CYCLIC_EN(1)) u_n8_d3 (
        .clk(clk), .reset(reset), .start(st[0]), .cyc(cy[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .busy(bz[0]), .done(dn[0]), .c(c0));
    gf2_digit_serial_mult #(.N(10), .D(4), .CYCLIC_EN(1)) u_n10_d4 (
        .clk(clk), .reset(reset), .start(st[1]), .cyc(cy[1]),
        .a(av[1][9:0]), .b(bv[1][9:0]), .busy(bz[1]), .done(dn[1]), .c(c1));
    gf2_digit_serial_mult #(.N(256), .D(16), .CYCLIC_EN(1)) u_n256_d16 (
        .clk(clk), .reset(reset), .start(st[2]), .cyc(cy[2]),
        .a(av[2]), .b(bv[2]), .busy(bz[2]), .done(dn[2]), .c(c2));
    gf2_digit_serial_mult #(.N(8), .D(8), .CYCLIC_EN(1)) u_n8_d8 (
        .clk(clk), .reset(reset), .start(st[3]), .cyc(cy[3]),
        .a(av[3][7:0]), .b(bv[3][7:0]), .busy(bz[3]), .done(dn[3]), .c(c3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           w;
        logic [255:0] x;
        logic [255:0] y;
        bit           cyc;
        logic [511:0] exp_c;
        int           exp_lat;
    } vec_t;

    function automatic logic [511:0] getc(input int w);
        case (w)
            0:       return 512'(c0);
            1:       return 512'(c1);
            2:       return c2;
            default: return 512'(c3);
        endcase
    endfunction

    // schoolbook product, then optional fold of coefficient i+n onto i
    function automatic logic [511:0] ref_mul(input int n, input logic [255:0] x, input logic [255:0] y, input bit fold);
        logic [511:0] p;
        logic [511:0] r;
        p = '0;
        r = '0;
        for (int i = 0; i < n; i++)
            if (x[i])
                for (int j = 0; j < n; j++)
                    if (y[j]) p[i+j] = ~p[i+j];
        if (!fold) return p;
        for (int i = 0; i < n; i++) r[i] = p[i] ^ p[i+n];
        return r;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic run_op(input int w, input logic [255:0] x, input logic [255:0] y, input bit cyc_in,
                          output logic [511:0] res, output int lat, output int bcnt);
        av[w] = x;
        bv[w] = y;
        cy[w] = cyc_in;
        st[w] = 1'b1;
        @(posedge clk); #1;
        st[w] = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!dn[w] && lat < 100) begin
            if (bz[w]) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = getc(w);
    endtask

    vec_t         tbl [8];
    logic [511:0] res;
    logic [255:0] rx;
    logic [255:0] ry;
    bit           rc;
    int           lat;
    int           bcnt;
    int           dcnt;

    initial begin
        checks   = 0;
        failures = 0;
        st       = '0;
        cy       = '0;
        for (int i = 0; i < 4; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end

        tbl[0] = '{0, 256'h03,  256'h03,  1'b0, 512'h0005,  4};
        tbl[1] = '{0, 256'hFF,  256'hFF,  1'b0, 512'h5555,  4};
        tbl[2] = '{0, 256'hFF,  256'hFF,  1'b1, 512'h0000,  4};
        tbl[3] = '{0, 256'h80,  256'h02,  1'b0, 512'h0100,  4};
        tbl[4] = '{0, 256'h80,  256'h02,  1'b1, 512'h0001,  4};
        tbl[5] = '{1, 256'h3FF, 256'h201, 1'b0, 512'h7FDFF, 4};
        tbl[6] = '{3, 256'h80,  256'h80,  1'b0, 512'h4000,  2};
        tbl[7] = '{3, 256'h80,  256'h80,  1'b1, 512'h0040,  2};

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_busy%0d", i), 512'(bz[i]), 512'(0));
            chk($sformatf("reset_done%0d", i), 512'(dn[i]), 512'(0));
            chk($sformatf("reset_c%0d", i), getc(i), 512'(0));
        end

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].w, tbl[i].x, tbl[i].y, tbl[i].cyc, res, lat, bcnt);
            chk($sformatf("vec%0d_c", i), res, tbl[i].exp_c);
            chk($sformatf("vec%0d_latency", i), 512'(lat), 512'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_busy_cycles", i), 512'(bcnt), 512'(tbl[i].exp_lat));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), 512'(dn[tbl[i].w]), 512'(0));
            chk($sformatf("vec%0d_c_hold", i), getc(tbl[i].w), tbl[i].exp_c);
        end

        // start held high through the op with different operands must not disturb it
        av[0] = 256'h80;
        bv[0] = 256'h02;
        cy[0] = 1'b0;
        st[0] = 1'b1;
        @(posedge clk); #1;
        av[0] = 256'hFF;
        bv[0] = 256'hFF;
        cy[0] = 1'b1;
        lat   = 0;
        while (!dn[0] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        st[0] = 1'b0;
        chk("held_start_c", 512'(c0), 512'h0100);
        chk("held_start_latency", 512'(lat), 512'(4));
        repeat (3) @(posedge clk);
        #1;
        chk("held_start_c_stable", 512'(c0), 512'h0100);
        chk("held_start_idle", 512'(bz[0]), 512'(0));

        // reset while RUN with k=1 aborts silently
        av[0] = 256'hFF;
        bv[0] = 256'hFF;
        cy[0] = 1'b0;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 512'(bz[0]), 512'(0));
        chk("abort_done", 512'(dn[0]), 512'(0));
        chk("abort_c", 512'(c0), 512'(0));
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (dn[0]) dcnt++;
        end
        chk("abort_no_done", 512'(dcnt), 512'(0));
        run_op(0, 256'h03, 256'h03, 1'b0, res, lat, bcnt);
        chk("after_abort_c", res, 512'h0005);
        chk("after_abort_latency", 512'(lat), 512'(4));

        for (int n = 0; n < 200; n++) begin
            for (int q = 0; q < 8; q++) begin
                rx[q*32 +: 32] = $urandom;
                ry[q*32 +: 32] = $urandom;
            end
            rc = 1'($urandom & 1);
            run_op(2, rx, ry, rc, res, lat, bcnt);
            chk($sformatf("rand%0d_c_cyc%0d", n, rc), res, ref_mul(256, rx, ry, rc));
            chk($sformatf("rand%0d_latency", n), 512'(lat), 512'(17));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
